// File: rtl/vwb_pkg.sv
// Shared types and default widths for the victim write buffer.
package vwb_pkg;

    localparam int VWB_ADDR_W = 28;
    localparam int VWB_LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP   = 2'd1,
        MREAD  = 2'd2,
        MDRAIN = 2'd3
    } vwb_state_t;

    typedef struct packed {
        logic [VWB_ADDR_W-1:0] addr;
        logic [VWB_LINE_W-1:0] data;
    } vwb_entry_t;

endpackage

// File: rtl/victim_write_buffer_if.sv
// Line-granular memory port: one protocol used both upstream (cache side)
// and downstream (memory side) of the write buffer.
interface victim_write_buffer_if
    import vwb_pkg::*;
#(
    parameter int ADDR_W = VWB_ADDR_W,
    parameter int LINE_W = VWB_LINE_W
);

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              ready;

    modport master (
        output read, write, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  read, write, addr, wdata,
        output rdata, ready
    );

endinterface

// File: rtl/vwb_store.sv
// Entry storage for the write buffer: register array with valid bits,
// parallel address lookup and head read-out.
module vwb_store
    import vwb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = VWB_ADDR_W,
    parameter int LINE_W = VWB_LINE_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              push_i,
    input  logic [PTR_W-1:0]  push_idx_i,
    input  logic              pop_i,
    input  logic [PTR_W-1:0]  head_idx_i,
    input  logic              ovr_i,
    input  logic [PTR_W-1:0]  ovr_idx_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [LINE_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              match_o,
    output logic [PTR_W-1:0]  match_idx_o,
    output logic [LINE_W-1:0] match_data_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [LINE_W-1:0] head_data_o
);

    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];

    // Only the valid bits need clearing; stale payload is never observed.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            valid_q <= '0;
        end else begin
            if (pop_i) begin
                valid_q[head_idx_i] <= 1'b0;
            end
            if (push_i) begin
                valid_q[push_idx_i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[push_idx_i] <= wr_addr_i;
            data_q[push_idx_i] <= wr_data_i;
        end else if (ovr_i) begin
            data_q[ovr_idx_i] <= wr_data_i;
        end
    end

    // Writes coalesce, so at most one valid entry can hit.
    always_comb begin
        match_o     = 1'b0;
        match_idx_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == lookup_addr_i)) begin
                match_o     = 1'b1;
                match_idx_o = PTR_W'(i);
            end
        end
    end

    assign match_data_o = data_q[match_idx_o];
    assign head_addr_o  = addr_q[head_idx_i];
    assign head_data_o  = data_q[head_idx_i];

endmodule

// File: rtl/victim_write_buffer.sv
// Dirty-line write buffer between the data cache and main memory: absorbs
// write-backs, forwards hits to reads, and drains to memory when idle.
//
//   state  | meaning
//   IDLE   | evaluate upstream request or start a drain of the head entry
//   RESP   | cache_ready pulse; upstream request ignored this cycle
//   MREAD  | read miss outstanding downstream
//   MDRAIN | head entry being written to memory
module victim_write_buffer
    import vwb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = VWB_ADDR_W,
    parameter int LINE_W = VWB_LINE_W
) (
    input logic                   clk,
    input logic                   proc_reset,
    victim_write_buffer_if.slave  cache,
    victim_write_buffer_if.master mem
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    vwb_state_t        state_q;
    logic              cache_ready_q;
    logic [LINE_W-1:0] cache_rdata_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              match;
    logic [PTR_W-1:0]  match_idx;
    logic [LINE_W-1:0] match_data;
    logic [ADDR_W-1:0] head_addr;
    logic [LINE_W-1:0] head_data;

    logic              in_idle;
    logic              wr_only;
    logic              full;
    logic              push;
    logic              ovr;
    logic              pop;

    assign in_idle = (state_q == IDLE);
    assign wr_only = cache.write && !cache.read;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign push    = in_idle && wr_only && !match && !full;
    assign ovr     = in_idle && wr_only && match;
    assign pop     = (state_q == MDRAIN) && mem.ready;

    vwb_store #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W)
    ) u_store (
        .clk          (clk),
        .proc_reset   (proc_reset),
        .push_i       (push),
        .push_idx_i   (tail_q),
        .pop_i        (pop),
        .head_idx_i   (head_q),
        .ovr_i        (ovr),
        .ovr_idx_i    (match_idx),
        .wr_addr_i    (cache.addr),
        .wr_data_i    (cache.wdata),
        .lookup_addr_i(cache.addr),
        .match_o      (match),
        .match_idx_o  (match_idx),
        .match_data_o (match_data),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data)
    );

    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q       <= IDLE;
            cache_ready_q <= 1'b0;
            cache_rdata_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            cache_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cache.read) begin
                        if (match) begin
                            cache_rdata_q <= match_data;
                            cache_ready_q <= 1'b1;
                            state_q       <= RESP;
                        end else begin
                            mem_read_q <= 1'b1;
                            mem_addr_q <= cache.addr;
                            state_q    <= MREAD;
                        end
                    end else if (cache.write && (match || !full)) begin
                        cache_ready_q <= 1'b1;
                        state_q       <= RESP;
                    end else if (cache.write || (count_q != '0)) begin
                        // Full-buffer writes stay pending and retry after this drain.
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= head_addr;
                        mem_wdata_q <= head_data;
                        state_q     <= MDRAIN;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                MREAD: begin
                    if (mem.ready) begin
                        cache_rdata_q <= mem.rdata;
                        cache_ready_q <= 1'b1;
                        mem_read_q    <= 1'b0;
                        state_q       <= RESP;
                    end
                end
                MDRAIN: begin
                    if (mem.ready) begin
                        mem_write_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cache.ready = cache_ready_q;
    assign cache.rdata = cache_rdata_q;
    assign mem.read    = mem_read_q;
    assign mem.write   = mem_write_q;
    assign mem.addr    = mem_addr_q;
    assign mem.wdata   = mem_wdata_q;

endmodule

// File: doc/victim_write_buffer.md
# victim_write_buffer

Dirty-line write buffer between the data cache's memory port and main memory. It absorbs cache write-backs in a small FIFO and answers each write in two cycles, letting the cache's following line refill go to memory first. Buffered lines drain to memory when no refill is pending. It presents the memory-side protocol upstream and issues the same protocol downstream, so it drops transparently into the cache–memory path.

## Interface
- DEPTH, 2: buffer entries; power of two, 2..8.
- ADDR_W, 28: line address width.
- LINE_W, 128: line data width.

Ports:
- clk  in  1  clock; all state on rising edge.
- proc_reset  in  1  reset; asynchronous, active-high.
- cache_read  in  1  line read request, held until cache_ready.
- cache_write  in  1  line write (write-back) request, held until cache_ready.
- cache_addr  in  ADDR_W  line address.
- cache_wdata  in  LINE_W  write-back data.
- cache_rdata  out  LINE_W  read data; valid when cache_ready=1.
- cache_ready  out  1  one-cycle completion pulse.
- mem_read / mem_write  out  1  downstream request; registered; held until mem_ready.
- mem_addr  out  ADDR_W  downstream line address.
- mem_wdata  out  LINE_W  downstream write data.
- mem_rdata  in  LINE_W  memory read data; sampled when mem_ready=1.
- mem_ready  in  1  memory completion pulse.

## Operation
- Storage: circular FIFO of DEPTH entries {addr, data}, with head/tail pointers ($clog2(DEPTH) bits, natural wrap) and count ($clog2(DEPTH)+1 bits).
- A buffered line address appears in at most one entry (writes coalesce), so lookup returns at most one match.
- FSM states: IDLE, RESP, MREAD, MDRAIN.
- IDLE, priority order:
  1. cache_read with buffer match: load cache_rdata from the matching entry; go to RESP.
  2. cache_read, no match: set mem_read=1, mem_addr=cache_addr; go to MREAD. A read bypasses non-matching buffered writes.
  3. cache_write with match: overwrite that entry's data in place; go to RESP.
  4. cache_write, no match, count<DEPTH: push at tail; go to RESP.
  5. cache_write, buffer full: start a drain of the head and go to MDRAIN. The write stays pending and is re-evaluated in IDLE.
  6. No request, count>0: start a drain of the head (mem_write=1, mem_addr/mem_wdata from head); go to MDRAIN.
  7. Otherwise stay in IDLE.
- Simultaneous cache_read and cache_write is illegal; the read wins.
- MREAD: on mem_ready, cache_rdata<=mem_rdata and mem_read<=0; go to RESP.
- MDRAIN: on mem_ready, pop head (head+1, count-1) and mem_write<=0; go to IDLE. A request arriving mid-drain waits.
- RESP: cache_ready=1 for exactly this cycle, then IDLE. The upstream request is ignored in RESP, because the requester still holds it that cycle.
- mem_addr and mem_wdata hold stable while a request is outstanding. mem_read and mem_write are never both 1.
- Reset mid-operation clears all state. Buffered dirty lines are discarded, and any outstanding memory request is abandoned.

## Timing
- Reset values: cache_ready=0, cache_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, state=IDLE, count=0, head=tail=0.
- Write accept (not full) or read forward: request seen in IDLE at edge N; cache_ready=1 in cycle N+1.
- Read miss: mem_read is asserted the cycle after the request is seen. cache_ready comes 1 cycle after mem_ready.
- Write when full: cache_ready comes 2 cycles after the drain's mem_ready (IDLE re-evaluation, then RESP).
- A drain starts at the earliest 1 cycle after RESP, and only if no new request is present in that IDLE cycle.
- Count never exceeds DEPTH; pointers wrap from DEPTH-1 to 0.

## Structure
- Package vwb_pkg holds:
  - ADDR_W and LINE_W defaults
  - FSM state enum {IDLE, RESP, MREAD, MDRAIN}
  - entry struct {addr, data}
- One sub-module, vwb_store: DEPTH-entry register array with push, pop and overwrite ports, a parallel address compare giving match/match_idx, and head read data.
- The top level holds the FSM, the output registers and the pointer/count logic.

## Test plan
- Reset, then idle with the buffer empty: all outputs stay 0 and no memory request is issued.
- Write A=0x0000010, D=0x11..11: cache_ready 2 cycles after the request. An immediate read of 0x0000100 goes to memory before the drain; after that, mem_write with addr 0x0000010, D=0x11..11 is issued.
- Write A=0x20, then read A=0x20 before the drain: returns the buffered data, with mem_read never asserted.
- Write A twice with D1 then D2: count stays 1 and the single drain carries D2.
- DEPTH=2, three writes to distinct addresses with memory latency 5: the third is acknowledged only after the first drain's mem_ready. Drains go out in FIFO order, with pointers wrapping.
- Assert proc_reset during MDRAIN with count=2: all outputs are 0 immediately. After release, no drain occurs and a read miss proceeds normally.
